uart_rx_packet_ctrl: RTL and testbench

Packet sequencer behind the UART receiver. Consumes 9-bit words (rx_data, rx_done, rx_framing_error) and assembles them into fixed-length command packets: one header word followed by PAYLOAD_WORDS payload words. It validates framing, times out stalled packets and hands each complete packet to the command decoder over a valid/ready handshake. Bad or orphaned words are dropped and counted.

---
 rtl/uart_rx_packet_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// Packet sequencer behind the UART receiver: assembles one header word plus
// PAYLOAD_WORDS payload words into a packet and offers it over valid/ready.
// Orphaned words, abandoned packets, framing errors and overruns are dropped
// and counted in a saturating 8-bit counter.
module uart_rx_packet_ctrl #(
  parameter int unsigned PAYLOAD_WORDS  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 60000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [8:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rx_framing_error,
  output logic [7:0]                 pkt_header,
  output logic [8*PAYLOAD_WORDS-1:0] pkt_payload,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic [7:0]                 drop_count
);

  localparam int unsigned PAY_W = 8 * PAYLOAD_WORDS;
  localparam int unsigned CNT_W = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t             state, state_n;
  logic [7:0]         header_n;
  logic [PAY_W-1:0]   payload_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               overrun_n;
  logic [7:0]         drop_n;
  logic               drop_inc;
  logic               fe_prev;
  logic               framing_event;
  logic               is_header;

  // Rising edge of the framing-error level; a held level counts once.
  assign framing_event = rx_framing_error & ~fe_prev;
  assign is_header     = rx_data[8];

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_n   = state;
    header_n  = pkt_header;
    payload_n = pkt_payload;
    cnt_n     = cnt;
    timer_n   = timer;
    overrun_n = 1'b0;
    drop_inc  = 1'b0;
    drop_n    = drop_count;

    case (state)
      IDLE: begin
        if (framing_event) begin
          drop_inc = 1'b1;
        end else if (rx_done) begin
          if (is_header) begin
            header_n = rx_data[7:0];
            cnt_n    = '0;
            timer_n  = '0;
            state_n  = COLLECT;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end

      COLLECT: begin
        timer_n = timer + TMR_W'(1);
        if (framing_event) begin
          // framing wins over a same-cycle word
          drop_inc = 1'b1;
          state_n  = IDLE;
        end else if (rx_done) begin
          timer_n = '0;
          if (is_header) begin
            // restart on a fresh header, old packet abandoned
            drop_inc = 1'b1;
            header_n = rx_data[7:0];
            cnt_n    = '0;
          end else begin
            for (int k = 0; k < int'(PAYLOAD_WORDS); k++) begin
              if (cnt == CNT_W'(k)) payload_n[8*k +: 8] = rx_data[7:0];
            end
            if (cnt == CNT_LAST) state_n = HOLD;
            else                 cnt_n   = cnt + CNT_W'(1);
          end
        end else if (timer == TMR_LAST) begin
          drop_inc = 1'b1;
          state_n  = IDLE;
        end
      end

      HOLD: begin
        if (framing_event) drop_inc = 1'b1;
        if (rx_done && !pkt_ready) begin
          overrun_n = 1'b1;
          drop_inc  = 1'b1;
        end
        if (pkt_ready) begin
          state_n = IDLE;
          if (rx_done && !framing_event) begin
            if (is_header) begin
              header_n = rx_data[7:0];
              cnt_n    = '0;
              timer_n  = '0;
              state_n  = COLLECT;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    if (drop_inc && (drop_count != 8'hFF)) drop_n = drop_count + 8'd1;
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pkt_header  <= '0;
      pkt_payload <= '0;
      cnt         <= '0;
      timer       <= '0;
      overrun     <= 1'b0;
      drop_count  <= '0;
      pkt_valid   <= 1'b0;
      busy        <= 1'b0;
      fe_prev     <= 1'b0;
    end else begin
      state       <= state_n;
      pkt_header  <= header_n;
      pkt_payload <= payload_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      overrun     <= overrun_n;
      drop_count  <= drop_n;
      pkt_valid   <= (state_n == HOLD);
      busy        <= (state_n != IDLE);
      fe_prev     <= rx_framing_error;
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Scoreboard bench for uart_rx_packet_ctrl: directed scenarios followed by
// randomized transactions; expected packets are queued by the driver and
// checked by an independent monitor at each handshake.
module tb_uart_rx_packet_ctrl;

  localparam int unsigned PW = 2;
  localparam int unsigned TO = 100;

  typedef struct packed {
    logic [7:0]      h;
    logic [8*PW-1:0] p;
  } pkt_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [8:0]      rx_data;
  logic            rx_done;
  logic            rx_framing_error;
  logic [7:0]      pkt_header;
  logic [8*PW-1:0] pkt_payload;
  logic            pkt_valid;
  logic            pkt_ready;
  logic            busy;
  logic            overrun;
  logic [7:0]      drop_count;

  int   total = 0;
  int   bad = 0;
  int   exp_drop = 0;
  int   ov_seen = 0;
  bit   rand_ready = 1'b0;
  pkt_t exp_q[$];

  uart_rx_packet_ctrl #(.PAYLOAD_WORDS(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .rx_framing_error(rx_framing_error), .pkt_header(pkt_header),
    .pkt_payload(pkt_payload), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .busy(busy), .overrun(overrun), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every handshake, count overrun pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (overrun) ov_seen++;
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt", 32'(pkt_header), 32'hFFFF_FFFF);
        end else begin
          pkt_t e;
          e = exp_q.pop_front();
          check("pkt_header", 32'(pkt_header), 32'(e.h));
          check("pkt_payload", 32'(pkt_payload), 32'(e.p));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  function automatic void add_drop();
    if (exp_drop < 255) exp_drop++;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) pkt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [8:0] w);
    rx_data = w;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || pkt_valid) && n < 300) begin
      step();
      n++;
    end
    check("reach_idle", 32'(busy | pkt_valid), 32'd0);
  endtask

  function automatic logic [8:0] rand_hdr();
    return {1'b1, 8'($urandom_range(0, 255))};
  endfunction

  function automatic logic [8:0] rand_pay();
    return {1'b0, 8'($urandom_range(0, 255))};
  endfunction

  // Sends a complete random packet with random gaps and queues it.
  task automatic send_good_packet();
    pkt_t        e;
    logic [8:0]  w;
    w   = rand_hdr();
    e.h = w[7:0];
    e.p = '0;
    send_word(w);
    for (int k = 0; k < int'(PW); k++) begin
      repeat ($urandom_range(0, 3)) step();
      w = rand_pay();
      e.p[8*k +: 8] = w[7:0];
      if (k == int'(PW) - 1) exp_q.push_back(e);
      send_word(w);
    end
  endtask

  // Header plus 0..PW-1 payload words, leaving the packet incomplete.
  task automatic send_partial();
    send_word(rand_hdr());
    repeat ($urandom_range(0, PW - 1)) send_word(rand_pay());
  endtask

  initial begin
    pkt_t e;
    int   ov0;
    reset = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    rx_framing_error = 1'b0;
    pkt_ready = 1'b0;
    repeat (3) step();
    check("rst_valid", 32'(pkt_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_hdr_pay", {8'd0, pkt_header, pkt_payload}, 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    step();

    // Basic packet with ready held high
    pkt_ready = 1'b1;
    e.h = 8'hA5; e.p = 16'hC433;
    exp_q.push_back(e);
    send_word(9'h1A5); send_word(9'h033); send_word(9'h0C4);
    check("t1_valid_on", 32'(pkt_valid), 1);
    check("t1_hdr", 32'(pkt_header), 32'hA5);
    check("t1_pay", 32'(pkt_payload), 32'hC433);
    step();
    check("t1_valid_off", 32'(pkt_valid), 0);
    check("t1_drop", 32'(drop_count), 32'(exp_drop));

    // Held packet, overrun while held
    pkt_ready = 1'b0;
    e.h = 8'hC3; e.p = 16'h55AA;
    exp_q.push_back(e);
    send_word(9'h1C3); send_word(9'h0AA); send_word(9'h055);
    for (int i = 0; i < 50; i++) begin
      check("t2_stable", {7'd0, pkt_valid, pkt_header, pkt_payload}, {7'd0, 1'b1, 8'hC3, 16'h55AA});
      step();
    end
    ov0 = ov_seen;
    send_word(9'h011);
    add_drop();
    check("t2_overrun_on", 32'(overrun), 1);
    check("t2_stable_after", {7'd0, pkt_valid, pkt_header, pkt_payload}, {7'd0, 1'b1, 8'hC3, 16'h55AA});
    step();
    check("t2_overrun_off", 32'(overrun), 0);
    check("t2_overrun_once", 32'(ov_seen - ov0), 1);
    check("t2_drop", 32'(drop_count), 32'(exp_drop));
    pkt_ready = 1'b1;
    step();
    check("t2_valid_off", 32'(pkt_valid), 0);

    // Header restart abandons the partial packet
    e.h = 8'hB6; e.p = 16'h0201;
    exp_q.push_back(e);
    send_word(9'h1A5); send_word(9'h011);
    send_word(9'h1B6); send_word(9'h001); send_word(9'h002);
    add_drop();
    step();
    check("t3_drop", 32'(drop_count), 32'(exp_drop));
    check("t3_idle", 32'(pkt_valid | busy), 0);

    // Held-high framing error counts once
    send_word(9'h1D0); send_word(9'h007);
    rx_framing_error = 1'b1;
    step();
    check("t4_busy_off", 32'(busy), 0);
    repeat (19) step();
    rx_framing_error = 1'b0;
    step();
    add_drop();
    check("t4_drop", 32'(drop_count), 32'(exp_drop));
    send_word(9'h055);
    add_drop();
    check("t4_orphan_drop", 32'(drop_count), 32'(exp_drop));
    check("t4_busy", 32'(busy), 0);

    // Timeout exactly after TO cycles, then saturation
    send_word(9'h1E1);
    repeat (TO - 1) step();
    check("t5_busy_before", 32'(busy), 1);
    step();
    add_drop();
    check("t5_busy_at_timeout", 32'(busy), 0);
    check("t5_drop", 32'(drop_count), 32'(exp_drop));
    for (int i = 0; i < 300; i++) begin
      send_word(rand_pay());
      add_drop();
    end
    check("t5_drop_model", 32'(drop_count), 32'(exp_drop));
    check("t5_drop_sat", 32'(drop_count), 255);

    // Reset while holding a packet
    pkt_ready = 1'b0;
    send_word(9'h1F0); send_word(9'h012); send_word(9'h034);
    check("t6_valid_held", 32'(pkt_valid), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(pkt_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_drop", 32'(drop_count), 0);
    exp_drop = 0;
    step();
    reset = 1'b0;
    step();
    pkt_ready = 1'b1;
    e.h = 8'h42; e.p = 16'h9988;
    exp_q.push_back(e);
    send_word(9'h142); send_word(9'h088); send_word(9'h099);
    step();
    check("t6_after_drop", 32'(drop_count), 32'(exp_drop));
    check("t6_q_drained", 32'(exp_q.size()), 0);

    // Randomized transactions
    rand_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0: send_good_packet();
        1: begin send_word(rand_pay()); add_drop(); end
        2: begin
          rx_framing_error = 1'b1;
          repeat ($urandom_range(1, 4)) step();
          rx_framing_error = 1'b0;
          step();
          add_drop();
        end
        3: begin send_partial(); add_drop(); send_good_packet(); end
        4: begin
          send_partial();
          rx_framing_error = 1'b1;
          step();
          rx_framing_error = 1'b0;
          step();
          add_drop();
        end
        default: begin
          send_partial();
          repeat (TO + 2) step();
          add_drop();
        end
      endcase
      wait_idle();
      check("rand_drop", 32'(drop_count), 32'(exp_drop));
    end
    rand_ready = 1'b0;
    pkt_ready = 1'b0;
    step();
    check("final_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
